load_unit: RTL and testbench
============================

LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 Parameter: MAX_WAIT, default 15, maximum number of WAIT cycles before a bus timeout (legal range 1..255).
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  load request from the MEM stage.
REQ-005 req_ready  output  1  unit can accept a request; high only in IDLE.
REQ-006 req_addr  input  32  byte address of the load.
REQ-007 req_lwhb  input  2  load size: 01 word, 10 halfword, 11 byte, 00 treated as word (same encoding as the store byte-mask size field).
REQ-008 req_unsigned  input  1  1 = zero-extend (lbu/lhu), 0 = sign-extend.
REQ-009 req_rd  input  5  destination register index.
REQ-010 stall  output  1  pipeline hold request.
REQ-011 bus_re  output  1  registered data-memory read strobe.
REQ-012 bus_addr  output  32  registered word-aligned read address.
REQ-013 bus_ack  input  1  memory read data valid.
REQ-014 bus_rdata  input  32  memory read word.
REQ-015 wb_valid  output  1  one-cycle pulse marking valid writeback data.
REQ-016 wb_rd  output  5  writeback register index.
REQ-017 wb_data  output  32  aligned, extended load result.
REQ-018 err  output  1  one-cycle error pulse.
REQ-019 err_code  output  2  01 misaligned, 10 timeout, 00 none.

Function
REQ-020 The unit SHALL implement three states: IDLE, WAIT, DONE.
REQ-021 A request SHALL be accepted only when req_valid=1 and the unit is in IDLE; addr, lwhb, unsigned and rd SHALL be latched on that edge.
REQ-022 On acceptance the FSM SHALL enter WAIT with bus_re=1 and bus_addr={req_addr[31:2],2'b00}; the wait counter SHALL clear to 0.
REQ-023 In WAIT, bus_ack=1 SHALL cause extracted data to be latched into wb_data, bus_re=0, and a transition to DONE.
REQ-024 In WAIT without bus_ack, the counter SHALL increment; when the counter equals MAX_WAIT-1, the FSM SHALL go to DONE with err_code=10, so that exactly MAX_WAIT WAIT cycles are spent.
REQ-025 If bus_ack arrives on the final timeout cycle, the ack SHALL win: normal completion, no error.
REQ-026 DONE SHALL last exactly one cycle: wb_valid=1 (on success) or err=1 (on error, wb_valid=0), then return to IDLE.
REQ-027 Extraction: word = rdata; halfword = addr[1] ? rdata[31:16] : rdata[15:0]; byte = the byte selected by addr[1:0]; the result SHALL be extended to 32 bits per req_unsigned.
REQ-028 stall SHALL equal (state==WAIT) | (state==IDLE & req_valid); stall SHALL be low in DONE, and req_valid presented in DONE SHALL be ignored.
REQ-029 bus_ack in IDLE or DONE SHALL be ignored.
REQ-030 Latency from accept to wb_valid SHALL be N+2 cycles, where N is the number of WAIT cycles before ack (minimum 1).

Reset
REQ-031 While reset is high: state=IDLE, bus_re=0, bus_addr=0, wb_valid=0, wb_rd=0, wb_data=0, err=0, err_code=00, counter=0; req_ready=1; stall follows req_valid.
REQ-032 Reset asserted mid-transaction SHALL immediately drop bus_re and abandon the load; a late bus_ack SHALL produce no writeback.

Configuration
REQ-033 Macro LOAD_ALIGN_CHECK_EN: when defined, a halfword with addr[0]=1 or a word with addr[1:0]!=00 SHALL NOT assert bus_re; the FSM SHALL go from IDLE directly to DONE with err=1, err_code=01, wb_valid=0.
REQ-034 When LOAD_ALIGN_CHECK_EN is undefined, low address bits not used by REQ-027 SHALL be ignored, and err_code 01 SHALL never occur.

Verification
REQ-035 lb addr 0x103, ack on 2nd WAIT cycle, rdata 0x80FF1234 -> wb_data 0xFFFFFF80, wb_valid one cycle, 4 cycles after accept; lbu -> 0x00000080.
REQ-036 lh addr 0x202, rdata 0x80017FFF -> wb_data 0xFFFF8001; lhu -> 0x00008001; bus_addr 0x200.
REQ-037 MAX_WAIT=4, no ack -> 4 WAIT cycles, then err=1, err_code=10, wb_valid=0, req_ready=1 the next cycle.
REQ-038 lw addr 0x101: with macro -> bus_re never high, err_code=01 one cycle after accept; without macro -> bus_addr 0x100, wb_data=rdata.
REQ-039 Reset pulse during WAIT, then bus_ack=1 -> bus_re=0 at once, no wb_valid, req_ready=1.
REQ-040 MAX_WAIT=4, ack on the 4th WAIT cycle, rdata 0x12345678, lw -> wb_valid=1, wb_data 0x12345678, err=0.

Source files
------------

// File: rtl/load_unit.sv
// rtl/load_unit.sv - Data-memory load unit: request latch, bus read with timeout, align and extend.
// Optional LOAD_ALIGN_CHECK_EN: reject misaligned halfword/word loads with err_code 01.
module load_unit #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_lwhb,
  input  logic        req_unsigned,
  input  logic [4:0]  req_rd,
  output logic        stall,
  output logic        bus_re,
  output logic [31:0] bus_addr,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [1:0]  addr_lo;
  logic [1:0]  size;
  logic        is_unsigned;
  logic [31:0] load_data;
  logic [15:0] half;
  logic [7:0]  byte_sel;
  logic        misaligned;

  assign req_ready = (state == IDLE);
  assign stall     = (state == WAIT) | ((state == IDLE) & req_valid);

`ifdef LOAD_ALIGN_CHECK_EN
  assign misaligned = (req_lwhb == 2'b10) ? req_addr[0]
                                          : ((req_lwhb != 2'b11) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Extraction uses the latched request fields against the word arriving with bus_ack.
  always_comb begin
    half      = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    byte_sel  = bus_rdata[7:0];
    case (addr_lo)
      2'b01:   byte_sel = bus_rdata[15:8];
      2'b10:   byte_sel = bus_rdata[23:16];
      2'b11:   byte_sel = bus_rdata[31:24];
      default: byte_sel = bus_rdata[7:0];
    endcase
    case (size)
      2'b10:   load_data = {{16{~is_unsigned & half[15]}}, half};
      2'b11:   load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      default: load_data = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= 8'd0;
      addr_lo     <= 2'b00;
      size        <= 2'b00;
      is_unsigned <= 1'b0;
      bus_re      <= 1'b0;
      bus_addr    <= 32'd0;
      wb_valid    <= 1'b0;
      wb_rd       <= 5'd0;
      wb_data     <= 32'd0;
      err         <= 1'b0;
      err_code    <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_lo     <= req_addr[1:0];
            size        <= req_lwhb;
            is_unsigned <= req_unsigned;
            wb_rd       <= req_rd;
            wait_cnt    <= 8'd0;
            if (misaligned) begin
              state    <= DONE;
              err      <= 1'b1;
              err_code <= 2'b01;
            end else begin
              state    <= WAIT;
              bus_re   <= 1'b1;
              bus_addr <= {req_addr[31:2], 2'b00};
            end
          end
        end
        WAIT: begin
          // An ack on the last allowed cycle still completes normally.
          if (bus_ack) begin
            wb_data  <= load_data;
            wb_valid <= 1'b1;
            bus_re   <= 1'b0;
            state    <= DONE;
          end else if (wait_cnt == LAST_WAIT) begin
            bus_re   <= 1'b0;
            err      <= 1'b1;
            err_code <= 2'b10;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE: begin
          wb_valid <= 1'b0;
          err      <= 1'b0;
          err_code <= 2'b00;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// tb/tb_load_unit.sv - Randomized self-checking bench for load_unit against a reference model.
module tb_load_unit;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_lwhb;
  logic        req_unsigned;
  logic [4:0]  req_rd;
  logic        stall;
  logic        bus_re;
  logic [31:0] bus_addr;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_errors = 0;

  load_unit #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_lwhb(req_lwhb), .req_unsigned(req_unsigned), .req_rd(req_rd),
    .stall(stall), .bus_re(bus_re), .bus_addr(bus_addr),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: shift the selected lane down, mask to size, extend by the sign bit.
  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] sz,
                                           input logic uns, input logic [31:0] rdata);
    logic [31:0] v;
    int sh;
    case (sz)
      2'b11: begin
        sh = 8 * int'(addr[1:0]);
        v  = (rdata >> sh) & 32'h0000_00FF;
        if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end
      2'b10: begin
        sh = 16 * int'(addr[1]);
        v  = (rdata >> sh) & 32'h0000_FFFF;
        if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = rdata;
    endcase
    return v;
  endfunction

  function automatic logic ref_misaligned(input logic [31:0] addr, input logic [1:0] sz);
`ifdef LOAD_ALIGN_CHECK_EN
    if (sz == 2'b10) return addr[0];
    if (sz == 2'b11) return 1'b0;
    return addr[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // Entered at posedge+1 with the unit idle; returns at posedge+1 with the unit idle again.
  // ack_at: WAIT cycle (1-based) that carries bus_ack; outside 1..MAX_WAIT means no ack.
  task automatic do_load(input logic [31:0] addr, input logic [1:0] sz, input logic uns,
                         input logic [4:0] rd, input int ack_at, input logic [31:0] rdata);
    logic [31:0] exp_data;
    logic        mis;
    logic        timeout;
    int          n_wait;
    exp_data = ref_load(addr, sz, uns, rdata);
    mis      = ref_misaligned(addr, sz);
    timeout  = !(ack_at >= 1 && ack_at <= MAX_WAIT);
    n_wait   = timeout ? MAX_WAIT : ack_at;

    check("ready_idle", req_ready, 1);
    req_valid = 1'b1; req_addr = addr; req_lwhb = sz; req_unsigned = uns; req_rd = rd;
    #1;
    check("stall_req", stall, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_rd = 5'($urandom);

    if (mis) begin
      check("mis_err", err, 1);
      check("mis_code", err_code, 2'b01);
      check("mis_bus_re", bus_re, 0);
      check("mis_wb_valid", wb_valid, 0);
    end else begin
      for (int k = 1; k <= n_wait; k++) begin
        check("wait_bus_re", bus_re, 1);
        check("wait_bus_addr", bus_addr, {addr[31:2], 2'b00});
        check("wait_stall", stall, 1);
        check("wait_no_wb", wb_valid, 0);
        check("wait_no_err", err, 0);
        check("wait_not_ready", req_ready, 0);
        bus_ack   = (k == ack_at);
        bus_rdata = (k == ack_at) ? rdata : $urandom;
        @(posedge clk); #1;
        bus_ack = 1'b0;
      end
      check("done_wb_valid", wb_valid, !timeout);
      check("done_err", err, timeout);
      check("done_code", err_code, timeout ? 2'b10 : 2'b00);
      check("done_bus_re", bus_re, 0);
      if (!timeout) begin
        check("done_wb_data", wb_data, exp_data);
        check("done_wb_rd", wb_rd, rd);
      end
    end

    // Traffic during DONE must be ignored.
    req_valid = 1'($urandom_range(0, 1));
    bus_ack   = 1'($urandom_range(0, 1));
    #1;
    check("done_stall", stall, 0);
    check("done_not_ready", req_ready, 0);
    @(posedge clk); #1;
    req_valid = 1'b0; bus_ack = 1'b0;
    check("idle_ready", req_ready, 1);
    check("idle_wb_valid", wb_valid, 0);
    check("idle_err", err, 0);
    check("idle_code", err_code, 0);
    check("idle_bus_re", bus_re, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = 32'd0; req_lwhb = 2'b00;
    req_unsigned = 1'b0; req_rd = 5'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_bus_re", bus_re, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_err", err, 0);
    check("rst_code", err_code, 0);
    check("rst_ready", req_ready, 1);
    req_valid = 1'b1; #1;
    check("rst_stall_hi", stall, 1);
    req_valid = 1'b0; #1;
    check("rst_stall_lo", stall, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    do_load(32'h0000_0103, 2'b11, 1'b0, 5'd3, 2, 32'h80FF_1234);
    do_load(32'h0000_0103, 2'b11, 1'b1, 5'd4, 2, 32'h80FF_1234);
    do_load(32'h0000_0202, 2'b10, 1'b0, 5'd5, 1, 32'h8001_7FFF);
    do_load(32'h0000_0202, 2'b10, 1'b1, 5'd6, 3, 32'h8001_7FFF);
    do_load(32'h0000_0300, 2'b01, 1'b0, 5'd7, 0, 32'hDEAD_BEEF);
    do_load(32'h0000_0101, 2'b01, 1'b0, 5'd8, 1, 32'hCAFE_F00D);
    do_load(32'h0000_0400, 2'b01, 1'b0, 5'd9, MAX_WAIT, 32'h1234_5678);
    do_load(32'h0000_0401, 2'b00, 1'b1, 5'd10, 2, 32'h0BAD_F00D);

    for (int i = 0; i < 40; i++)
      do_load($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom),
              $urandom_range(0, MAX_WAIT + 1), $urandom);

    // Reset in the middle of a WAIT, followed by a stray ack.
    req_valid = 1'b1; req_addr = 32'h0000_0500; req_lwhb = 2'b01; req_rd = 5'd11;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid_bus_re", bus_re, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_bus_re", bus_re, 0);
    check("mid_rst_ready", req_ready, 1);
    check("mid_rst_wb_valid", wb_valid, 0);
    #1 reset = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("late_ack_wb_valid", wb_valid, 0);
      check("late_ack_err", err, 0);
      check("late_ack_bus_re", bus_re, 0);
      check("late_ack_ready", req_ready, 1);
    end
    bus_ack = 1'b0;
    @(posedge clk); #1;
    do_load(32'h0000_0602, 2'b11, 1'b0, 5'd12, 1, 32'h00FE_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
